// File: rtl/mem_writeback_arbiter_if.sv
// Writeback return bus between N memory/IO return paths (master) and the arbiter (slave).
// Each lane is a valid/ready pair: an entry moves on a clock edge where both WbValid[i] and WbReady[i] are high.
interface mem_writeback_arbiter_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int PORTCOUNT       = 4
);
    logic [PORTCOUNT-1:0]                      WbValid;
    logic [PORTCOUNT-1:0]                      WbReady;
    logic [PORTCOUNT-1:0][DATABITWIDTH-1:0]    WbData;
    logic [PORTCOUNT-1:0][REGADDRBITWIDTH-1:0] WbAddr;

    modport master (
        output WbValid,
        output WbData,
        output WbAddr,
        input  WbReady
    );

    modport slave (
        input  WbValid,
        input  WbData,
        input  WbAddr,
        output WbReady
    );
endinterface

// File: rtl/mem_writeback_arbiter.sv
// Buffers per-port writeback returns in small FIFOs and arbitrates them (round-robin or
// fixed priority) into a single registered register-file write port.
module mem_writeback_arbiter #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int PORTCOUNT       = 4,
    parameter int PORTADDRWIDTH   = 2,
    parameter int FIFODEPTH       = 4,
    parameter int FIFOPTRWIDTH    = 2,
    parameter int DISCARDZERO     = 1
) (
    input  logic                       clk,
    input  logic                       clk_en,
    input  logic                       sync_rst,
    input  logic                       PriorityMode,
    mem_writeback_arbiter_if.slave     wb,
    output logic                       RegWriteEn,
    output logic [DATABITWIDTH-1:0]    RegWriteData,
    output logic [REGADDRBITWIDTH-1:0] RegWriteAddr,
    output logic [PORTADDRWIDTH-1:0]   RegWritePort,
    output logic                       WbIdle
);

    logic [DATABITWIDTH-1:0]    r_fifo_data [PORTCOUNT][FIFODEPTH];
    logic [REGADDRBITWIDTH-1:0] r_fifo_addr [PORTCOUNT][FIFODEPTH];
    logic [FIFOPTRWIDTH-1:0]    r_rd_ptr    [PORTCOUNT];
    logic [FIFOPTRWIDTH-1:0]    r_wr_ptr    [PORTCOUNT];
    logic [FIFOPTRWIDTH:0]      r_count     [PORTCOUNT];
    logic [PORTADDRWIDTH-1:0]   r_rr_ptr;

    logic                       r_reg_write_en;
    logic [DATABITWIDTH-1:0]    r_reg_write_data;
    logic [REGADDRBITWIDTH-1:0] r_reg_write_addr;
    logic [PORTADDRWIDTH-1:0]   r_reg_write_port;

    logic [PORTCOUNT-1:0]       w_empty;
    logic [PORTCOUNT-1:0]       w_full;
    logic [PORTCOUNT-1:0]       w_ready;
    logic [PORTCOUNT-1:0]       w_push;
    logic [PORTCOUNT-1:0]       w_pop;
    logic                       w_grant_valid;
    logic [PORTADDRWIDTH-1:0]   w_grant;
    logic [PORTADDRWIDTH-1:0]   w_rr_next;
    logic [DATABITWIDTH-1:0]    w_head_data;
    logic [REGADDRBITWIDTH-1:0] w_head_addr;
    logic                       w_head_discard;
    int                         w_scan_idx;

    // Full/empty come from registered occupancy only, so a full FIFO never accepts
    // in the same cycle it pops and requests never see a same-cycle push.
    assign w_ready    = {PORTCOUNT{clk_en & sync_rst}} & ~w_full;
    assign w_push     = wb.WbValid & w_ready;
    assign wb.WbReady = w_ready;

    genvar gi;
    generate
        for (gi = 0; gi < PORTCOUNT; gi++) begin : g_port
            assign w_empty[gi] = (r_count[gi] == '0);
            assign w_full[gi]  = (r_count[gi] == (FIFOPTRWIDTH+1)'(FIFODEPTH));
            assign w_pop[gi]   = w_grant_valid && (w_grant == PORTADDRWIDTH'(gi));

            always_ff @(posedge clk) begin
                if (!sync_rst) begin
                    r_rd_ptr[gi] <= '0;
                    r_wr_ptr[gi] <= '0;
                    r_count[gi]  <= '0;
                end else if (clk_en) begin
                    if (w_push[gi]) begin
                        r_wr_ptr[gi] <= r_wr_ptr[gi] + FIFOPTRWIDTH'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr[gi] <= r_rd_ptr[gi] + FIFOPTRWIDTH'(1);
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count[gi] <= r_count[gi] + (FIFOPTRWIDTH+1)'(1);
                        2'b01:   r_count[gi] <= r_count[gi] - (FIFOPTRWIDTH+1)'(1);
                        default: r_count[gi] <= r_count[gi];
                    endcase
                end
            end

            // Storage needs no reset: push is impossible while reset is asserted.
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_fifo_data[gi][r_wr_ptr[gi]] <= wb.WbData[gi];
                    r_fifo_addr[gi][r_wr_ptr[gi]] <= wb.WbAddr[gi];
                end
            end
        end
    endgenerate

    // Scan order starts at the RR pointer in round-robin mode, at port 0 in fixed mode.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_scan_idx    = 0;
        for (int k = 0; k < PORTCOUNT; k++) begin
            if (PriorityMode) begin
                w_scan_idx = k;
            end else begin
                w_scan_idx = int'(r_rr_ptr) + k;
                if (w_scan_idx >= PORTCOUNT) begin
                    w_scan_idx = w_scan_idx - PORTCOUNT;
                end
            end
            if (!w_grant_valid && !w_empty[PORTADDRWIDTH'(w_scan_idx)]) begin
                w_grant_valid = 1'b1;
                w_grant       = PORTADDRWIDTH'(w_scan_idx);
            end
        end
    end

    assign w_rr_next      = (w_grant == PORTADDRWIDTH'(PORTCOUNT-1)) ? '0 : w_grant + PORTADDRWIDTH'(1);
    assign w_head_data    = r_fifo_data[w_grant][r_rd_ptr[w_grant]];
    assign w_head_addr    = r_fifo_addr[w_grant][r_rd_ptr[w_grant]];
    assign w_head_discard = (DISCARDZERO != 0) && (w_head_addr == '0);

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            r_rr_ptr         <= '0;
            r_reg_write_en   <= 1'b0;
            r_reg_write_data <= '0;
            r_reg_write_addr <= '0;
            r_reg_write_port <= '0;
        end else if (clk_en) begin
            if (w_grant_valid) begin
                r_reg_write_en   <= ~w_head_discard;
                r_reg_write_data <= w_head_data;
                r_reg_write_addr <= w_head_addr;
                r_reg_write_port <= w_grant;
                if (!PriorityMode) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else begin
                r_reg_write_en <= 1'b0;
            end
        end
    end

    assign RegWriteEn   = r_reg_write_en;
    assign RegWriteData = r_reg_write_data;
    assign RegWriteAddr = r_reg_write_addr;
    assign RegWritePort = r_reg_write_port;
    assign WbIdle       = (&w_empty) & ~r_reg_write_en;

endmodule

// File: tb/tb_mem_writeback_arbiter.sv
// Directed self-checking bench for mem_writeback_arbiter: reset, latency, RR/fixed arbitration,
// back-pressure, zero-address discard, clock-enable hold and mid-stream reset.
module tb_mem_writeback_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int PC = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          clk_en;
  logic          sync_rst;
  logic          PriorityMode;
  logic          RegWriteEn;
  logic [DW-1:0] RegWriteData;
  logic [AW-1:0] RegWriteAddr;
  logic [PW-1:0] RegWritePort;
  logic          WbIdle;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW+AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_writeback_arbiter_if #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(AW), .PORTCOUNT(PC)) wb_if ();

  mem_writeback_arbiter dut (
    .clk          (clk),
    .clk_en       (clk_en),
    .sync_rst     (sync_rst),
    .PriorityMode (PriorityMode),
    .wb           (wb_if),
    .RegWriteEn   (RegWriteEn),
    .RegWriteData (RegWriteData),
    .RegWriteAddr (RegWriteAddr),
    .RegWritePort (RegWritePort),
    .WbIdle       (WbIdle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write seen must match the head of exp_q, in order.
  task automatic collect(input int budget, output int used);
    logic [PW+AW+DW-1:0] e;
    used = 0;
    while (exp_q.size() > 0 && used < budget) begin
      tick();
      used++;
      if (RegWriteEn) begin
        e = exp_q.pop_front();
        check("sb_write", {10'd0, RegWritePort, RegWriteAddr, RegWriteData}, {10'd0, e});
      end
    end
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    int k;
    int p0cnt;
    int p3cnt;
    int wcnt;
    logic acc;
    logic seen3;

    clk_en       = 1'b1;
    sync_rst     = 1'b0;
    PriorityMode = 1'b0;
    wb_if.WbValid = '0;
    wb_if.WbData  = '0;
    wb_if.WbAddr  = '0;

    // Reset state
    tick();
    tick();
    check("rst_we", RegWriteEn, 0);
    check("rst_data", RegWriteData, 0);
    check("rst_addr", RegWriteAddr, 0);
    check("rst_port", RegWritePort, 0);
    check("rst_idle", WbIdle, 1);
    check("rst_ready", wb_if.WbReady, 4'h0);
    sync_rst = 1'b1;
    #1;
    check("ready_after_rst", wb_if.WbReady, 4'hF);

    // Single push on port 2: write appears two edges later
    wb_if.WbValid   = 4'b0100;
    wb_if.WbData[2] = 16'hBEEF;
    wb_if.WbAddr[2] = 4'd5;
    tick();
    wb_if.WbValid = '0;
    check("lat_not_yet", RegWriteEn, 0);
    tick();
    check("lat_we", RegWriteEn, 1);
    check("lat_addr", RegWriteAddr, 5);
    check("lat_data", RegWriteData, 16'hBEEF);
    check("lat_port", RegWritePort, 2);
    check("lat_busy", WbIdle, 0);
    tick();
    check("lat_we_off", RegWriteEn, 0);
    check("lat_idle", WbIdle, 1);

    // Round robin from pointer 0: reset to clear pointer, then all four push together
    sync_rst = 1'b0;
    tick();
    sync_rst = 1'b1;
    for (int i = 0; i < PC; i++) begin
      wb_if.WbData[i] = 16'hA000 + 16'(i * 16'h111);
      wb_if.WbAddr[i] = 4'(i + 1);
      exp_q.push_back({2'(i), 4'(i + 1), 16'hA000 + 16'(i * 16'h111)});
    end
    wb_if.WbValid = 4'b1111;
    tick();
    wb_if.WbValid = '0;
    collect(8, used);
    check("rr_cycles", used, 4);

    // Fixed priority: port 0 always refilled, port 3 starves
    PriorityMode    = 1'b1;
    wb_if.WbData[0] = 16'h0A00;
    wb_if.WbAddr[0] = 4'd1;
    wb_if.WbData[3] = 16'h3333;
    wb_if.WbAddr[3] = 4'd3;
    wb_if.WbValid   = 4'b1001;
    p0cnt = 0;
    p3cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (RegWriteEn && RegWritePort == 2'd0) p0cnt++;
      if (RegWriteEn && RegWritePort == 2'd3) p3cnt++;
    end
    check("fixed_p0_wins", p0cnt, 7);
    check("fixed_p3_starved", p3cnt, 0);
    check("fixed_p3_full", wb_if.WbReady[3], 0);
    PriorityMode = 1'b0;
    seen3 = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      if (RegWriteEn && RegWritePort == 2'd3) seen3 = 1'b1;
    end
    check("rr_switch_p3", seen3, 1);
    wb_if.WbValid = '0;
    for (int t = 0; t < 30 && !WbIdle; t++) tick();
    check("drain_idle", WbIdle, 1);

    // Back-pressure on port 1 while port 0 holds the grant
    PriorityMode    = 1'b1;
    wb_if.WbData[0] = 16'h0A0A;
    wb_if.WbAddr[0] = 4'd3;
    wb_if.WbData[1] = 16'h1100;
    wb_if.WbAddr[1] = 4'd9;
    wb_if.WbValid   = 4'b0011;
    k = 0;
    for (int t = 0; t < 10 && k < 4; t++) begin
      acc = wb_if.WbReady[1];
      tick();
      if (acc) begin
        k++;
        wb_if.WbData[1] = 16'h1100 + 16'(k);
      end
    end
    check("bp_accepts", k, 4);
    check("bp_ready_low", wb_if.WbReady[1], 0);
    tick();
    check("bp_still_full", wb_if.WbReady[1], 0);
    check("bp_p0_granted", RegWritePort, 0);
    wb_if.WbValid = 4'b0010;
    tick();
    check("bp_last_p0", RegWritePort, 0);
    check("bp_full_on_p0", wb_if.WbReady[1], 0);
    tick();
    check("bp_first_pop", {RegWriteEn, RegWritePort, RegWriteAddr, RegWriteData}, {1'b1, 2'd1, 4'd9, 16'h1100});
    check("bp_ready_back", wb_if.WbReady[1], 1);
    tick();
    check("bp_second_pop", RegWriteData, 16'h1101);
    wb_if.WbValid = '0;
    exp_q.push_back({2'd1, 4'd9, 16'h1102});
    exp_q.push_back({2'd1, 4'd9, 16'h1103});
    exp_q.push_back({2'd1, 4'd9, 16'h1104});
    collect(10, used);
    tick();
    check("bp_idle", WbIdle, 1);

    // Zero-address entries are popped without a write
    wb_if.WbData[0] = 16'hDEAD;
    wb_if.WbAddr[0] = 4'd0;
    wb_if.WbValid   = 4'b0001;
    tick();
    wb_if.WbData[0] = 16'h0777;
    wb_if.WbAddr[0] = 4'd7;
    tick();
    wb_if.WbValid = '0;
    check("dz_no_we", RegWriteEn, 0);
    tick();
    check("dz_we", {RegWriteEn, RegWriteAddr, RegWriteData}, {1'b1, 4'd7, 16'h0777});
    wcnt = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (RegWriteEn) wcnt++;
    end
    check("dz_single_pulse", wcnt, 0);

    // clk_en low for three cycles mid-stream holds everything
    wb_if.WbData[2] = 16'h2001;
    wb_if.WbAddr[2] = 4'hA;
    wb_if.WbValid   = 4'b0100;
    tick();
    wb_if.WbData[2] = 16'h2002;
    tick();
    check("ce_first", {RegWriteEn, RegWriteData}, {1'b1, 16'h2001});
    wb_if.WbData[2] = 16'h2003;
    clk_en = 1'b0;
    #1;
    check("ce_ready_low", wb_if.WbReady, 4'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("ce_hold", {RegWriteEn, RegWritePort, RegWriteData}, {1'b1, 2'd2, 16'h2001});
    end
    clk_en = 1'b1;
    tick();
    wb_if.WbValid = '0;
    check("ce_resume", RegWriteData, 16'h2002);
    tick();
    check("ce_last", {RegWriteEn, RegWriteData}, {1'b1, 16'h2003});
    tick();
    check("ce_done", {RegWriteEn, WbIdle}, 2'b01);

    // Reset with three entries buffered drops them
    for (int i = 0; i < 3; i++) begin
      wb_if.WbData[i] = 16'h5550 + 16'(i);
      wb_if.WbAddr[i] = 4'(i + 1);
    end
    wb_if.WbValid = 4'b0111;
    tick();
    wb_if.WbValid = '0;
    sync_rst = 1'b0;
    tick();
    check("mrst_outputs", {RegWriteEn, RegWritePort, RegWriteAddr, RegWriteData}, 23'd0);
    check("mrst_idle", WbIdle, 1);
    check("mrst_ready", wb_if.WbReady, 4'h0);
    sync_rst = 1'b1;
    wcnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (RegWriteEn) wcnt++;
    end
    check("mrst_no_writes", wcnt, 0);
    check("mrst_final_idle", WbIdle, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
